// File: rtl/word_serialize_tx.sv
// Word-link transmitter: serializes 32-bit frames MSB-first, two bits per clock, one word per
// 16-clock slot, with a sync preamble after enable and zero fill when nothing is queued.
//
//   state    | meaning
//   IDLE     | transmitting zero words, waiting for i_enable at a word boundary
//   PREAMBLE | sending SYNC_WORD frames so the far-end aligner can lock
//   DATA     | popping FIFO words; real frames go out, malformed ones become zeros
module word_serialize_tx #(
  parameter logic [31:0] SYNC_WORD       = 32'h8000_4000,
  parameter int          PREAMBLE_WORDS  = 4,
  parameter int          RESYNC_INTERVAL = 0
) (
  input  logic        i_ddr_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pop,
  output logic [1:0]  o_ddr_data,
  output logic        o_drop,
  output logic [15:0] o_drop_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_WORDS - 1);
  localparam logic [15:0] RS_LIM   = 16'(RESYNC_INTERVAL);

  state_t      state, state_nxt;
  logic [3:0]  slot;
  logic [31:0] sreg;
  logic [31:0] word_nxt;
  logic [15:0] pre_cnt, pre_nxt;
  logic [15:0] rs_cnt, rs_nxt;
  logic [15:0] drop_cnt;
  logic        pop, drop;
  logic        boundary;
  logic        fifo_real, fifo_zero;

  assign boundary  = (slot == 4'hF);
  assign fifo_real = (i_fifo_data[31:30] == 2'b10) && !i_fifo_data[16] &&
                     (i_fifo_data[15:14] == 2'b01) && !i_fifo_data[0];
  assign fifo_zero = (i_fifo_data == 32'h0);

  always_comb begin
    state_nxt = state;
    pre_nxt   = pre_cnt;
    rs_nxt    = rs_cnt;
    word_nxt  = 32'h0;
    pop       = 1'b0;
    drop      = 1'b0;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            state_nxt = PREAMBLE;
            pre_nxt   = 16'd0;
          end
        end
        PREAMBLE: begin
          if (!i_enable) begin
            state_nxt = IDLE;
          end else begin
            word_nxt = SYNC_WORD;
            pre_nxt  = pre_cnt + 16'd1;
            if (pre_cnt >= PRE_LAST) begin
              state_nxt = DATA;
              rs_nxt    = 16'd0;
            end
          end
        end
        DATA: begin
          if (!i_enable) begin
            state_nxt = IDLE;
          end else if ((RS_LIM != 16'd0) && (rs_cnt >= RS_LIM)) begin
            // Resync slot: send one zero word, then replay the preamble.
            state_nxt = PREAMBLE;
            pre_nxt   = 16'd0;
          end else begin
            if (RS_LIM != 16'd0) rs_nxt = rs_cnt + 16'd1;
            if (!i_fifo_empty) begin
              pop = 1'b1;
              if (fifo_real)      word_nxt = i_fifo_data;
              else if (!fifo_zero) drop    = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      slot       <= 4'd0;
      sreg       <= 32'h0;
      pre_cnt    <= 16'd0;
      rs_cnt     <= 16'd0;
      drop_cnt   <= 16'd0;
      o_ddr_data <= 2'b00;
    end else begin
      state      <= state_nxt;
      slot       <= slot + 4'd1;
      pre_cnt    <= pre_nxt;
      rs_cnt     <= rs_nxt;
      o_ddr_data <= sreg[31:30];
      sreg       <= boundary ? word_nxt : {sreg[29:0], 2'b00};
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Pop and drop are same-cycle strobes so the FIFO advances on the load edge.
  assign o_fifo_pop   = pop  & ~i_rst;
  assign o_drop       = drop & ~i_rst;
  assign o_drop_count = drop_cnt;
  assign o_state      = state;

endmodule

// File: tb/tb_word_serialize_tx.sv
// Scoreboard bench for word_serialize_tx: directed FIFO traffic, words reassembled from the
// DDR pair and compared against hand-listed expected words; a second instance exercises resync.
module tb_word_serialize_tx;

  localparam logic [31:0] SYNC = 32'h8000_4000;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        en;
  logic        fifo_empty, fifo2_empty;
  logic [31:0] fifo_data, fifo2_data;
  logic        pop, pop2, drop, drop2;
  logic [1:0]  ddr, ddr2, st, st2;
  logic [15:0] drop_count, drop_count2;

  logic [31:0] exp_q[$];
  logic [31:0] q2[$];
  logic [31:0] fq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, cyc2 = 0;
  int pops = 0, drops = 0;
  int n2 = 1;

  always #5 clk = ~clk;

  word_serialize_tx u_dut (
    .i_ddr_clk(clk), .i_rst(rst), .i_enable(en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_pop(pop), .o_ddr_data(ddr), .o_drop(drop),
    .o_drop_count(drop_count), .o_state(st)
  );

  word_serialize_tx #(.RESYNC_INTERVAL(3)) u_rs (
    .i_ddr_clk(clk), .i_rst(rst2), .i_enable(1'b1), .i_fifo_empty(fifo2_empty),
    .i_fifo_data(fifo2_data), .o_fifo_pop(pop2), .o_ddr_data(ddr2), .o_drop(drop2),
    .o_drop_count(drop_count2), .o_state(st2)
  );

  function automatic logic [31:0] dword(input int n);
    logic [31:0] v;
    v = 32'h8000_4000 | (32'(n) << 20) | (32'(n) << 1);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Local slot trackers: the DUT slot equals cyc mod 16 after each edge.
  initial forever begin
    @(posedge clk);
    if (rst) cyc = 0; else cyc++;
    if (rst2) cyc2 = 0; else cyc2++;
  end

  // Main FIFO model plus pop/drop observer.
  initial begin
    logic p;
    fifo_empty = 1'b1;
    fifo_data  = 32'h0;
    forever begin
      @(negedge clk);
      p = pop;
      if (p) begin
        n_checks++;
        if ((cyc % 16) != 15 || fq.size() == 0) begin
          n_fail++;
          $display("FAIL pop_timing: pop at slot %0d with %0d queued, required slot 15 and non-empty",
                   cyc % 16, fq.size());
        end
        pops++;
      end
      if (drop) drops++;
      @(posedge clk);
      #2;
      if (p && fq.size() != 0) void'(fq.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_data  = (fq.size() == 0) ? 32'h0 : fq[0];
    end
  end

  // Resync instance FIFO: always full with a stream of distinct real words.
  initial begin
    logic p2;
    fifo2_empty = 1'b0;
    fifo2_data  = dword(1);
    forever begin
      @(negedge clk);
      p2 = pop2;
      @(posedge clk);
      #2;
      if (p2) n2++;
      fifo2_data = dword(n2);
    end
  end

  // Monitor: reassemble 16 symbols into a word and score it.
  initial begin
    logic [31:0] acc = 32'h0, e;
    bit act = 1'b0;
    int nsym = 0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if ((cyc % 16) == 1) begin
        acc = {30'h0, ddr}; nsym = 1; act = 1'b1;
      end else if (act) begin
        acc = {acc[29:0], ddr};
        nsym++;
        if (nsym == 16) begin
          act = 1'b0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL word_unexpected: got %h with no word expected", acc);
          end else begin
            e = exp_q.pop_front();
            if (acc !== e) begin
              n_fail++;
              $display("FAIL word: got %h expected %h", acc, e);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] acc = 32'h0, e;
    bit act = 1'b0;
    int nsym = 0;
    forever begin
      @(negedge clk);
      if (rst2) act = 1'b0;
      else if ((cyc2 % 16) == 1) begin
        acc = {30'h0, ddr2}; nsym = 1; act = 1'b1;
      end else if (act) begin
        acc = {acc[29:0], ddr2};
        nsym++;
        if (nsym == 16) begin
          act = 1'b0;
          if (q2.size() != 0) begin
            e = q2.pop_front();
            n_checks++;
            if (acc !== e) begin
              n_fail++;
              $display("FAIL resync_word: got %h expected %h", acc, e);
            end
          end
        end
      end
    end
  end

  task automatic to_slot(input int s);
    do begin
      @(posedge clk);
      #1;
    end while ((cyc % 16) != s);
  endtask

  // Expect word w from the next boundary and advance past it.
  task automatic bnd(input logic [31:0] w);
    exp_q.push_back(w);
    to_slot(0);
  endtask

  // Resync instance: 0 (reset word), 0 (idle), then {4 sync, 3 data, 1 zero} repeating.
  initial begin
    int d = 1;
    rst2 = 1'b1;
    q2.push_back(32'h0);
    q2.push_back(32'h0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) q2.push_back(SYNC);
      for (int i = 0; i < 3; i++) begin q2.push_back(dword(d)); d++; end
      q2.push_back(32'h0);
    end
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_ddr", 32'(ddr), 32'h0);
    chk("reset_state", 32'(st), 32'h0);
    chk("reset_drop_count", 32'(drop_count), 32'h0);
    exp_q.push_back(32'h0);

    // Enabled with an empty FIFO: zero word, preamble, then zero fill.
    bnd(32'h0);
    repeat (4) bnd(SYNC);
    chk("state_data", 32'(st), 32'd2);
    repeat (3) bnd(32'h0);
    chk("no_pop_empty", 32'(pops), 32'd0);

    // Two real words back to back.
    fq.push_back(32'h9234_5678);
    fq.push_back(32'hA000_4002);
    bnd(32'h9234_5678);
    bnd(32'hA000_4002);
    bnd(32'h0);
    chk("pops_two_words", 32'(pops), 32'd2);

    // Malformed word between two real words.
    fq.push_back(32'h8124_4568);
    fq.push_back(32'hFFFF_FFFF);
    fq.push_back(32'hB00E_7FFE);
    bnd(32'h8124_4568);
    bnd(32'h0);
    bnd(32'hB00E_7FFE);
    bnd(32'h0);
    chk("drop_pulses", 32'(drops), 32'd1);
    chk("drop_count", 32'(drop_count), 32'd1);
    chk("pops_drop", 32'(pops), 32'd5);

    // Enable dropped mid-word: word completes, no pop, idle, full preamble on re-enable.
    fq.push_back(32'hA5A6_4A5A);
    bnd(32'hA5A6_4A5A);
    fq.push_back(32'h8000_4002);
    to_slot(5);
    en = 1'b0;
    bnd(32'h0);
    chk("state_idle", 32'(st), 32'd0);
    bnd(32'h0);
    bnd(32'h0);
    chk("pops_disabled", 32'(pops), 32'd6);
    chk("fifo_kept", 32'(fq.size()), 32'd1);
    en = 1'b1;
    bnd(32'h0);
    chk("state_preamble", 32'(st), 32'd1);
    repeat (4) bnd(SYNC);
    bnd(32'h8000_4002);
    bnd(32'h0);
    chk("pops_reenable", 32'(pops), 32'd7);

    // Reset mid-word: truncation, reset outputs, clean restart.
    fq.push_back(32'h9234_5678);
    bnd(32'h9234_5678);
    to_slot(7);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ddr", 32'(ddr), 32'h0);
    chk("rst_state", 32'(st), 32'h0);
    chk("rst_drop_count", 32'(drop_count), 32'h0);
    chk("rst_pop", 32'(pop), 32'h0);
    exp_q.push_back(32'h0);
    bnd(32'h0);
    repeat (4) bnd(SYNC);
    fq.push_back(32'hA000_4002);
    bnd(32'hA000_4002);
    bnd(32'h0);
    chk("pops_after_reset", 32'(pops), 32'd9);

    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    chk("words_pending", 32'(exp_q.size()), 32'd0);
    chk("resync_words_pending", 32'(q2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
